step_dir_decoder: RTL and testbench

Receive-side counterpart of the motor step/dir generator. It synchronises and glitch-filters external step/dir lines, tracks absolute position, and flags direction-setup violations. It also reports step rate per 4 ms window and whether the axis is moving. It sits between the step/dir pins (loopback from our generator or an external master) and the position-readback/control logic.

---
 rtl/motor_pkg.sv | 9 +
 rtl/sync_filter.sv | 34 +++
 rtl/step_dir_decoder.sv | 104 ++++++++++
 tb/tb_step_dir_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared step/dir constants and motion state type
// Used by the step/dir generator and by step_dir_decoder.
package motor_pkg;
  localparam int POS_W          = 16;
  localparam int FILTER_LEN_DEF = 4;
  localparam int DIR_SETUP_DEF  = 2;
  localparam int IDLE_TICKS_DEF = 244;
  typedef enum logic {IDLE, MOVING} motion_e;
endpackage

// File: rtl/sync_filter.sv
// sync_filter: 2-FF synchroniser followed by a glitch filter
// Ports: clk, rst_n (async active-low), din (asynchronous level),
//        dout (filtered level, changes after FILTER_LEN stable differing cycles)
module sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic       s1_q, s2_q, filt_q, filt_d, diff, hit;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    diff   = s2_q != filt_q;
    hit    = diff && cnt_q == 4'(FILTER_LEN - 1);
    filt_d = hit ? s2_q : filt_q;
    cnt_d  = (diff && !hit) ? cnt_q + 4'd1 : 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
  assign dout = filt_q;
endmodule

// File: rtl/step_dir_decoder.sv
// step_dir_decoder: filtered step/dir receiver with position, rate and motion tracking
// Ports: CLK_10MHZ, RST_N (async active-low), clock_4ms (window tick),
//        step_in/dir_in (async pins), load_pos/load_value (position preset),
//        clear_err; outputs position, step_pulse, step_dir, rate, moving, dir_err.
module step_dir_decoder
  import motor_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int DIR_SETUP  = DIR_SETUP_DEF,
  parameter int IDLE_TICKS = IDLE_TICKS_DEF
) (
  input  logic             CLK_10MHZ,
  input  logic             RST_N,
  input  logic             clock_4ms,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             load_pos,
  input  logic [POS_W-1:0] load_value,
  input  logic             clear_err,
  output logic [POS_W-1:0] position,
  output logic             step_pulse,
  output logic             step_dir,
  output logic [15:0]      rate,
  output logic             moving,
  output logic             dir_err
);
  localparam int IW = $clog2(IDLE_TICKS + 1);
  logic             step_f, dir_f, fall;
  logic             step0_q, step1_q, dir0_q;
  logic [3:0]       dir_age_q, dir_age_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             step_pulse_q, step_dir_q, step_dir_d, dir_err_q, dir_err_d;
  logic [15:0]      win_q, win_d, win_inc, rate_q, rate_d;
  logic [IW-1:0]    idle_q, idle_d;
  motion_e          state_q, state_d;

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_step (
    .clk(CLK_10MHZ), .rst_n(RST_N), .din(step_in), .dout(step_f));
  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dir (
    .clk(CLK_10MHZ), .rst_n(RST_N), .din(dir_in), .dout(dir_f));

  // step0/dir0 are equally delayed copies so pin-level dir/step alignment holds
  always_comb begin
    fall       = step1_q & ~step0_q;
    dir_age_d  = (dir_f != dir0_q) ? 4'd0 : (dir_age_q == 4'hF) ? dir_age_q : dir_age_q + 4'd1;
    position_d = load_pos ? load_value :
                 fall ? (dir0_q ? position_q + 1'b1 : position_q - 1'b1) : position_q;
    step_dir_d = fall ? dir0_q : step_dir_q;
    dir_err_d  = (fall && dir_age_q < 4'(DIR_SETUP)) ? 1'b1 : clear_err ? 1'b0 : dir_err_q;
    win_inc    = (win_q == 16'hFFFF) ? win_q : win_q + {15'd0, fall};
    win_d      = clock_4ms ? 16'd0 : win_inc;
    rate_d     = clock_4ms ? win_inc : rate_q;
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (fall) begin
      state_d = MOVING;
      idle_d  = IW'(IDLE_TICKS);
    end else if (state_q == MOVING && clock_4ms) begin
      idle_d  = idle_q - IW'(1);
      state_d = (idle_q == IW'(1)) ? IDLE : MOVING;
    end
  end

  always_comb moving = state_q == MOVING;

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      step0_q      <= 1'b0;
      step1_q      <= 1'b0;
      dir0_q       <= 1'b0;
      dir_age_q    <= 4'hF;
      position_q   <= '0;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
      dir_err_q    <= 1'b0;
      win_q        <= '0;
      rate_q       <= '0;
      idle_q       <= '0;
      state_q      <= IDLE;
    end else begin
      step0_q      <= step_f;
      step1_q      <= step0_q;
      dir0_q       <= dir_f;
      dir_age_q    <= dir_age_d;
      position_q   <= position_d;
      step_pulse_q <= fall;
      step_dir_q   <= step_dir_d;
      dir_err_q    <= dir_err_d;
      win_q        <= win_d;
      rate_q       <= rate_d;
      idle_q       <= idle_d;
      state_q      <= state_d;
    end
  end

  assign position   = position_q;
  assign step_pulse = step_pulse_q;
  assign step_dir   = step_dir_q;
  assign rate       = rate_q;
  assign dir_err    = dir_err_q;
endmodule

// File: tb/tb_step_dir_decoder.sv
// tb_step_dir_decoder: directed stimulus with a pin-history reference model
module tb_step_dir_decoder;
  localparam int FL = 4, DS = 2, IT = 244;
  logic clk = 0, rst_n = 0, clock_4ms = 0, step_in = 0, dir_in = 0, load_pos = 0, clear_err = 0;
  logic [15:0] load_value = '0;
  logic [15:0] position, rate;
  logic step_pulse, step_dir, moving, dir_err;
  int n_chk = 0, n_fail = 0, cyc_n = 0, n_pulse = 0, first_pulse = -1, fall_cyc = 0, snap = 0;

  always #50 clk = ~clk;

  step_dir_decoder dut (
    .CLK_10MHZ(clk), .RST_N(rst_n), .clock_4ms(clock_4ms), .step_in(step_in), .dir_in(dir_in),
    .load_pos(load_pos), .load_value(load_value), .clear_err(clear_err), .position(position),
    .step_pulse(step_pulse), .step_dir(step_dir), .rate(rate), .moving(moving), .dir_err(dir_err));

  // Reference model: pins are recorded per edge; a filtered level flips once the
  // last FL synchronised samples all disagree with it; a step is a 1->0 of the
  // filtered level, acted on two edges later together with the filtered dir.
  logic [FL+1:0] m_ssh = '0, m_dsh = '0;
  logic m_sf = 0, m_df = 0, m_fall, m_dq0;
  logic [2:0] m_sfh = '0, m_dfh = '0;
  logic [15:0] m_pos = '0, m_rate = '0, m_win = '0;
  logic m_pulse = 0, m_sdir = 0, m_mov = 0, m_err = 0;
  int m_idle = 0, m_age = 15;

  function automatic logic [15:0] sat(input logic [15:0] w, input logic f);
    return (w == 16'hFFFF) ? w : w + {15'd0, f};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ssh = '0; m_dsh = '0; m_sf = 0; m_df = 0; m_sfh = '0; m_dfh = '0;
      m_pos = '0; m_rate = '0; m_win = '0; m_pulse = 0; m_sdir = 0; m_mov = 0; m_err = 0;
      m_idle = 0; m_age = 15;
    end else begin
      m_fall  = m_sfh[2] & ~m_sfh[1];
      m_dq0   = m_dfh[1];
      m_pulse = m_fall;
      if (m_fall) m_sdir = m_dq0;
      if (load_pos) m_pos = load_value;
      else if (m_fall) m_pos = m_dq0 ? m_pos + 16'd1 : m_pos - 16'd1;
      if (m_fall && m_age < DS) m_err = 1;
      else if (clear_err) m_err = 0;
      if (clock_4ms) begin m_rate = sat(m_win, m_fall); m_win = '0; end
      else m_win = sat(m_win, m_fall);
      if (m_fall) begin m_mov = 1; m_idle = IT; end
      else if (m_mov && clock_4ms) begin m_idle--; if (m_idle == 0) m_mov = 0; end
      m_age = (m_dfh[0] != m_dfh[1]) ? 0 : (m_age < 15 ? m_age + 1 : 15);
      m_ssh = {m_ssh[FL:0], step_in};
      m_dsh = {m_dsh[FL:0], dir_in};
      if (m_ssh[FL+1:2] == {FL{~m_sf}}) m_sf = ~m_sf;
      if (m_dsh[FL+1:2] == {FL{~m_df}}) m_df = ~m_df;
      m_sfh = {m_sfh[1:0], m_sf};
      m_dfh = {m_dfh[1:0], m_df};
    end
  end

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (rst_n && step_pulse) begin
      n_pulse++;
      if (first_pulse < 0) first_pulse = cyc_n;
    end
    n_chk++;
    if ({position, step_pulse, step_dir, rate, moving, dir_err} !==
        {m_pos, m_pulse, m_sdir, m_rate, m_mov, m_err}) begin
      n_fail++;
      $display("FAIL model t=%0t pos %h/%h pulse %b/%b dir %b/%b rate %h/%h moving %b/%b err %b/%b",
               $time, position, m_pos, step_pulse, m_pulse, step_dir, m_sdir, rate, m_rate,
               moving, m_mov, dir_err, m_err);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    step_in = 1; cyc(8);
    step_in = 0; cyc(8);
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    check("reset_outputs", {position, step_pulse, step_dir, rate, moving, dir_err}, 0);
    cyc(1);
    rst_n = 1;
    cyc(2);
    // ten steps upward, first-pulse latency
    dir_in = 1;
    step_in = 1; cyc(8);
    step_in = 0; fall_cyc = cyc_n; cyc(8);
    repeat (9) step();
    cyc(10);
    @(negedge clk);
    check("latency", first_pulse - fall_cyc - 1, 7);
    check("pos_10", position, 16'd10);
    check("pulses_10", n_pulse, 10);
    check("moving_on", moving, 1);
    // downward wrap, then load coincident with a step
    load_pos = 1; load_value = 16'h0000; cyc(1); load_pos = 0;
    dir_in = 0; cyc(10);
    step(); cyc(10);
    @(negedge clk);
    check("pos_wrap", position, 16'hFFFF);
    cyc(1);
    step_in = 1; cyc(8);
    step_in = 0; cyc(7);
    load_pos = 1; load_value = 16'h1234; cyc(1); load_pos = 0;
    @(negedge clk);
    check("load_pulse", step_pulse, 1);
    check("load_wins", position, 16'h1234);
    cyc(10);
    // glitches
    snap = n_pulse;
    step_in = 1; cyc(3); step_in = 0; cyc(20);
    @(negedge clk);
    check("glitch_pulses", n_pulse, snap);
    check("glitch_pos", position, 16'h1234);
    cyc(1);
    dir_in = 1; cyc(3); dir_in = 0; cyc(20);
    step(); cyc(10);
    @(negedge clk);
    check("dir_glitch_dir", step_dir, 0);
    check("dir_glitch_pos", position, 16'h1233);
    cyc(1);
    // direction setup violation
    step_in = 1; cyc(7);
    dir_in = 1; cyc(1);
    step_in = 0; cyc(10);
    @(negedge clk);
    check("dir_err_set", dir_err, 1);
    check("dir_err_counted", position, 16'h1234);
    cyc(1);
    clear_err = 1; cyc(1); clear_err = 0;
    @(negedge clk);
    check("dir_err_clear", dir_err, 0);
    cyc(1);
    step_in = 1; cyc(7);
    dir_in = 0; cyc(1);
    step_in = 0; cyc(7);
    clear_err = 1; cyc(1); clear_err = 0;
    @(negedge clk);
    check("dir_err_set_wins", dir_err, 1);
    cyc(10);
    dir_in = 1; cyc(20);
    // rate window of 50 steps, last one coincident with the tick
    clock_4ms = 1; cyc(1); clock_4ms = 0;
    repeat (49) step();
    step_in = 1; cyc(8);
    step_in = 0; cyc(7);
    clock_4ms = 1; cyc(1); clock_4ms = 0;
    @(negedge clk);
    check("rate_50", rate, 16'd50);
    cyc(8);
    repeat (3) step();
    clock_4ms = 1; cyc(1); clock_4ms = 0;
    @(negedge clk);
    check("rate_3", rate, 16'd3);
    cyc(1);
    // idle timeout
    step(); cyc(10);
    for (int i = 1; i <= IT; i++) begin
      clock_4ms = 1; cyc(1); clock_4ms = 0;
      @(negedge clk);
      if (i >= IT - 1) check($sformatf("moving_tick_%0d", i), moving, (i < IT) ? 1 : 0);
      cyc(2);
    end
    // asynchronous reset mid-burst
    step(); step();
    step_in = 1; cyc(8);
    step_in = 0; cyc(3);
    #20 rst_n = 0;
    #1 check("async_reset", {position, step_pulse, step_dir, rate, moving, dir_err}, 0);
    cyc(3);
    rst_n = 1;
    step(); cyc(10);
    @(negedge clk);
    check("post_reset_pos", position, 16'd1);
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
